// File: rtl/optim_top_pkg.sv
// Shared state encoding, default timing and reply framing for the RFID tag baseband.
// Timing constants are in 50 MHz clock cycles.
package optim_top_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELIM,
        ST_DATA,
        ST_WAIT_T1,
        ST_REPLY
    } state_e;

    localparam logic [15:0] DELIM_MIN_DEF  = 16'd500;
    localparam logic [15:0] DELIM_MAX_DEF  = 16'd750;
    localparam logic [15:0] PIVOT_CYC_DEF  = 16'd940;
    localparam logic [15:0] SYM_MAX_DEF    = 16'd2000;
    localparam logic [7:0]  CMD_CODE_DEF   = 8'hC3;
    localparam logic [15:0] T1_CYC_DEF     = 16'd500;
    localparam logic [15:0] BIT_CYC_DEF    = 16'd1250;
    localparam logic [15:0] REPLY_DATA_DEF = 16'hA55A;

    localparam logic [3:0] PREAMBLE  = 4'b1010;
    localparam int         REPLY_LEN = 21;

    // Full reply frame, MSB first: preamble, payload, trailing dummy 1.
    function automatic logic [REPLY_LEN-1:0] build_reply(input logic [15:0] data);
        return {PREAMBLE, data, 1'b1};
    endfunction

endpackage

// File: rtl/fm0_encoder.sv
// FM0 serializer: on start, sends a REPLY_LEN-bit word MSB first, then forces dout low
// and pulses done for one cycle.
module fm0_encoder
    import optim_top_pkg::*;
#(
    parameter logic [15:0] BIT_CYC = BIT_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [REPLY_LEN-1:0] word,
    output logic                 dout,
    output logic                 done
);

    localparam logic [15:0] HALF_M1 = (BIT_CYC >> 1) - 16'd1;
    localparam logic [15:0] LAST    = BIT_CYC - 16'd1;

    logic                 busy_q, busy_d;
    logic                 dout_q, dout_d;
    logic                 done_q, done_d;
    logic [4:0]           idx_q, idx_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [REPLY_LEN-1:0] word_q, word_d;

    always_comb begin
        busy_d = busy_q;
        dout_d = dout_q;
        done_d = 1'b0;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        word_d = word_q;
        if (start && !busy_q) begin
            busy_d = 1'b1;
            word_d = word;
            idx_d  = 5'(REPLY_LEN - 1);
            cnt_d  = '0;
            dout_d = ~dout_q;
        end else if (busy_q) begin
            cnt_d = cnt_q + 16'd1;
            // A data-0 gets an extra transition at mid-bit.
            if (cnt_q == HALF_M1 && !word_q[idx_q]) begin
                dout_d = ~dout_q;
            end
            if (cnt_q == LAST) begin
                cnt_d = '0;
                if (idx_q == 5'd0) begin
                    busy_d = 1'b0;
                    dout_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    idx_d  = idx_q - 5'd1;
                    dout_d = ~dout_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            dout_q <= 1'b0;
            done_q <= 1'b0;
            idx_q  <= '0;
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            busy_q <= busy_d;
            dout_q <= dout_d;
            done_q <= done_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign dout = dout_q;
    assign done = done_q;

endmodule

// File: rtl/optim_top.sv
// RFID tag baseband: PIE command decoder and sequencing FSM; answers a matching
// command with a fixed FM0 reply after the T1 turnaround.
//
// state      | meaning
// IDLE       | waiting for a falling edge that may start a delimiter
// DELIM      | timing the delimiter low pulse
// DATA       | measuring PIE symbols falling edge to falling edge
// WAIT_T1    | turnaround delay before the reply
// REPLY      | FM0 encoder transmitting
module optim_top
    import optim_top_pkg::*;
#(
    parameter logic [15:0] DELIM_MIN  = DELIM_MIN_DEF,
    parameter logic [15:0] DELIM_MAX  = DELIM_MAX_DEF,
    parameter logic [15:0] PIVOT_CYC  = PIVOT_CYC_DEF,
    parameter logic [15:0] SYM_MAX    = SYM_MAX_DEF,
    parameter logic [7:0]  CMD_CODE   = CMD_CODE_DEF,
    parameter logic [15:0] T1_CYC     = T1_CYC_DEF,
    parameter logic [15:0] BIT_CYC    = BIT_CYC_DEF,
    parameter logic [15:0] REPLY_DATA = REPLY_DATA_DEF
) (
    input  logic clk_50m,
    input  logic rst_p,
    input  logic din,
    output logic dout
);

    localparam logic [REPLY_LEN-1:0] REPLY_WORD = build_reply(REPLY_DATA);

    logic        sync1_q, sync2_q, prev_q;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        started_q, started_d;
    logic        fall, rise, enc_start, enc_done;

    // Synchronizer and edge history idle high, matching the demodulator idle level.
    always_ff @(posedge clk_50m or negedge rst_p) begin
        if (!rst_p) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall      = prev_q & ~sync2_q;
    assign rise      = ~prev_q & sync2_q;
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign enc_start = (state_q == ST_WAIT_T1) && (cnt_q == T1_CYC - 16'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        started_d = started_q;
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_DELIM;
                    cnt_d   = '0;
                end
            end
            ST_DELIM: begin
                cnt_d = cnt_inc;
                if (rise) begin
                    cnt_d = '0;
                    if (cnt_q >= DELIM_MIN && cnt_q <= DELIM_MAX) begin
                        state_d   = ST_DATA;
                        bitcnt_d  = '0;
                        shreg_d   = '0;
                        started_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                cnt_d = cnt_inc;
                if (fall) begin
                    cnt_d     = '0;
                    started_d = 1'b1;
                    // The first falling edge only opens the first symbol.
                    if (started_q) begin
                        shreg_d  = {shreg_q[6:0], cnt_q >= PIVOT_CYC};
                        bitcnt_d = (bitcnt_q == 4'd15) ? bitcnt_q : bitcnt_q + 4'd1;
                    end
                end else if (cnt_q > SYM_MAX) begin
                    cnt_d = '0;
                    if (sync2_q && bitcnt_q == 4'd8 && shreg_q == CMD_CODE) begin
                        state_d = ST_WAIT_T1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_T1: begin
                cnt_d = cnt_inc;
                if (enc_start) begin
                    state_d = ST_REPLY;
                    cnt_d   = '0;
                end
            end
            ST_REPLY: begin
                if (enc_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_p) begin
        if (!rst_p) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            started_q <= started_d;
        end
    end

    fm0_encoder #(
        .BIT_CYC (BIT_CYC)
    ) u_fm0 (
        .clk   (clk_50m),
        .rst_n (rst_p),
        .start (enc_start),
        .word  (REPLY_WORD),
        .dout  (dout),
        .done  (enc_done)
    );

endmodule

// File: tb/tb_optim_top.sv
// Bench for optim_top: directed and randomized PIE frames against a frame-level model.
// All timing parameters are scaled down by 10 so every scenario fits a short run.
module tb_optim_top;

    localparam int DMIN  = 50;
    localparam int DMAX  = 75;
    localparam int PIVOT = 94;
    localparam int SYM   = 200;
    localparam int T1    = 50;
    localparam int BITC  = 126;
    localparam int HALF  = BITC / 2;
    localparam int CMD   = 8'hC3;
    localparam int LOW   = 25;
    localparam int D0    = 63;
    localparam int D1    = 125;
    localparam logic [20:0] REPLY_BITS = 21'b1010_1010010101011010_1;

    logic clk, rst_p, din, dout;
    int   cyc;
    int   checks, failures;
    int   sym_len[16];
    int   nsym;
    int   last_fall;

    optim_top #(
        .DELIM_MIN  (16'd50),
        .DELIM_MAX  (16'd75),
        .PIVOT_CYC  (16'd94),
        .SYM_MAX    (16'd200),
        .CMD_CODE   (8'hC3),
        .T1_CYC     (16'd50),
        .BIT_CYC    (16'd126),
        .REPLY_DATA (16'hA55A)
    ) dut (
        .clk_50m (clk),
        .rst_p   (rst_p),
        .din     (din),
        .dout    (dout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected dout level in each half-bit, MSB half first, from the FM0 rules.
    function automatic logic [41:0] fm0_halves(input logic [20:0] w);
        logic        lvl;
        logic [41:0] r;
        lvl = 1'b0;
        r   = '0;
        for (int i = 20; i >= 0; i--) begin
            lvl = ~lvl;
            r[2*i+1] = lvl;
            if (!w[i]) lvl = ~lvl;
            r[2*i] = lvl;
        end
        return r;
    endfunction

    // Frame-level decision: a reply is due only for a good delimiter and exactly CMD in 8 symbols.
    function automatic bit model_reply(input int delim);
        int v;
        v = 0;
        if (delim < DMIN || delim > DMAX || nsym != 8) return 1'b0;
        for (int i = 0; i < nsym; i++) v = v * 2 + ((sym_len[i] >= PIVOT) ? 1 : 0);
        return v == CMD;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_frame(input logic [15:0] val, input int n, input bit jitter);
        nsym = n;
        for (int i = 0; i < n; i++) begin
            if (val[n-1-i]) sym_len[i] = jitter ? int'($urandom_range(105, 170)) : D1;
            else            sym_len[i] = jitter ? int'($urandom_range(55, 85))   : D0;
        end
    endtask

    // Delimiter, a data-0 shaped start symbol, then the symbols; each symbol ends in a LOW-cycle low.
    task automatic send_frame(input int delim);
        din = 1'b0;
        wait_cyc(delim);
        din = 1'b1;
        wait_cyc(D0 - LOW);
        din = 1'b0;
        last_fall = cyc;
        wait_cyc(LOW);
        for (int i = 0; i < nsym; i++) begin
            din = 1'b1;
            wait_cyc(sym_len[i] - LOW);
            din = 1'b0;
            last_fall = cyc;
            wait_cyc(LOW);
        end
        din = 1'b1;
    endtask

    task automatic check_silent(input string name, input int n);
        int bad;
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (dout !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s: dout high on %0d cycles, required 0", name, bad);
        end
    endtask

    task automatic wait_rise(input string name, output bit seen, output int rise);
        seen = 1'b0;
        rise = 0;
        while (!seen && (cyc - last_fall) <= SYM + T1 + 60) begin
            @(negedge clk);
            if (dout === 1'b1) seen = 1'b1;
        end
        rise = cyc - last_fall;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_start: no reply within %0d cycles, required a reply", name, SYM + T1 + 60);
        end
    endtask

    task automatic check_reply(input string name);
        bit          seen;
        int          r;
        logic [41:0] obs, exp_v;
        wait_rise(name, seen, r);
        if (seen) begin
            checks++;
            if (r < SYM + T1 || r > SYM + T1 + 10) begin
                failures++;
                $display("FAIL %s_t1: first edge %0d cycles after last fall, required %0d..%0d",
                         name, r, SYM + T1, SYM + T1 + 10);
            end
            wait_cyc(HALF / 2);
            for (int h = 0; h < 42; h++) begin
                obs[41-h] = dout;
                wait_cyc(HALF);
            end
            exp_v = fm0_halves(REPLY_BITS);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL %s_wave: halves=%h required=%h", name, obs, exp_v);
            end
            checks++;
            if (dout !== 1'b0) begin
                failures++;
                $display("FAIL %s_end: dout=%b after reply, required 0", name, dout);
            end
            wait_cyc(20);
        end
    endtask

    task automatic run_frame(input string name, input int delim);
        send_frame(delim);
        if (model_reply(delim)) check_reply(name);
        else                    check_silent(name, SYM + T1 + 300);
        wait_cyc(10);
    endtask

    task automatic test_reset();
        rst_p = 1'b0;
        din   = 1'b1;
        check_silent("reset_hold", 500);
        @(negedge clk) rst_p = 1'b1;
        check_silent("post_reset_idle", 1000);
    endtask

    task automatic test_valid_cmd();
        set_frame(16'h00C3, 8, 1'b0);
        run_frame("valid_c3", 63);
    endtask

    task automatic test_wrong_code();
        set_frame(16'h00C2, 8, 1'b0);
        run_frame("wrong_code", 63);
        check_silent("wrong_code_long", 5000);
    endtask

    task automatic test_bad_delim();
        set_frame(16'h00C3, 8, 1'b0);
        run_frame("delim_short", 40);
        run_frame("delim_long", 80);
    endtask

    task automatic test_wrong_length();
        set_frame(16'h0187, 9, 1'b0);
        run_frame("nine_bits", 63);
        set_frame(16'h0061, 7, 1'b0);
        run_frame("seven_bits", 63);
    endtask

    task automatic test_stuck_low();
        din = 1'b0;
        wait_cyc(63);
        din = 1'b1;
        wait_cyc(D0 - LOW);
        din = 1'b0;
        wait_cyc(300);
        din = 1'b1;
        check_silent("stuck_low", 400);
        set_frame(16'h00C3, 8, 1'b0);
        run_frame("after_stuck", 63);
    endtask

    task automatic test_reset_mid_reply();
        bit          seen;
        int          r, hsel;
        logic [41:0] exp_v;
        set_frame(16'h00C3, 8, 1'b0);
        send_frame(63);
        wait_rise("mid_reply", seen, r);
        if (seen) begin
            // Pick the half of bit 10 where dout is high so the drop is observable.
            exp_v = fm0_halves(REPLY_BITS);
            hsel  = exp_v[41-20] ? 20 : 21;
            wait_cyc(hsel * HALF + HALF / 2);
            checks++;
            if (dout !== 1'b1) begin
                failures++;
                $display("FAIL pre_reset_level: dout=%b, required 1", dout);
            end
            #3 rst_p = 1'b0;
            #1;
            checks++;
            if (dout !== 1'b0) begin
                failures++;
                $display("FAIL async_reset_dout: dout=%b, required 0", dout);
            end
            check_silent("reset_mid_reply_hold", 10);
            @(negedge clk) rst_p = 1'b1;
            wait_cyc(20);
        end
        run_frame("after_reset", 63);
    endtask

    task automatic test_random_frames();
        int          delim, n, k;
        logic [15:0] val;
        for (int it = 0; it < 6; it++) begin
            k = int'($urandom_range(0, 9));
            if (k == 0)      delim = int'($urandom_range(35, 47));
            else if (k == 1) delim = int'($urandom_range(78, 90));
            else             delim = int'($urandom_range(53, 72));
            k = int'($urandom_range(0, 5));
            n = (k == 0) ? 7 : (k == 1) ? 9 : 8;
            if ($urandom_range(0, 1) == 1) val = (n == 9) ? 16'h0186 : 16'h00C3;
            else                           val = 16'($urandom);
            set_frame(val, n, 1'b1);
            run_frame("random", delim);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nsym     = 0;
        last_fall = 0;
        rst_p    = 1'b0;
        din      = 1'b1;
        test_reset();
        test_valid_cmd();
        test_wrong_code();
        test_bad_delim();
        test_wrong_length();
        test_stuck_low();
        test_reset_mid_reply();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/optim_top.md
Name: optim_top

Overview:
- Simplified RFID tag baseband top.
- Decodes a reader-to-tag PIE-coded command arriving serially on din.
- When the command matches a configured code, returns a fixed FM0-coded reply on dout after a turnaround delay.
- Sits between the analog demodulator output (din) and the backscatter modulator input (dout). Runs on the 50 MHz system clock.

Parameters:
- DELIM_MIN, 500, minimum delimiter low time in cycles (10 us).
- DELIM_MAX, 750, maximum delimiter low time in cycles (15 us).
- PIVOT_CYC, 940, symbol-length threshold in cycles; shorter is data-0, equal or longer is data-1.
- SYM_MAX, 2000, symbol-length limit in cycles; longer while din is high is end-of-frame.
- CMD_CODE, 8'hC3, command value that triggers a reply.
- T1_CYC, 500, cycles from end-of-frame detection to the first reply edge.
- BIT_CYC, 1250, FM0 bit period in cycles (40 kbps). Must be even.
- REPLY_DATA, 16'hA55A, reply payload, sent MSB first.

Ports:
- clk_50m  input  1  50 MHz system clock; all logic on the rising edge.
- rst_p  input  1  asynchronous active-low reset. Despite the name, 0 = reset asserted.
- din  input  1  PIE command from the demodulator; idle high; asynchronous to clk_50m.
- dout  output  1  FM0 backscatter data; idle low.

Behaviour:
- Reset (rst_p=0): all flops clear asynchronously. FSM=IDLE, counters=0, shift register=0, dout=0. The synchronizer flops reset to 1 (idle high).
- din passes through a 2-flop synchronizer. Edges are detected on the synchronized value. All timings below are measured on the synchronized signal (2-cycle input latency).
- Symbol counter: 16-bit, saturating at 16'hFFFF.
- IDLE: on a falling edge of din, clear the counter and go to DELIM.
- DELIM: counts while din is low. On the rising edge:
  - count in [DELIM_MIN, DELIM_MAX] → clear the bit counter and shift register, go to DATA, counter restarts;
  - otherwise → IDLE.
- DATA: the counter runs from one falling edge to the next. At each falling edge:
  - count < PIVOT_CYC → shift in 0; otherwise shift in 1;
  - the bit counter increments and saturates at 15;
  - the counter clears.
  The first falling edge after the delimiter only marks the start of the first symbol and shifts nothing in.
- End-of-frame in DATA: the counter exceeds SYM_MAX while din is high. Then:
  - bit count == 8 and shift register == CMD_CODE → go to WAIT_T1;
  - else → IDLE with dout unchanged (0).
- Low too long in DATA: if din stays low longer than SYM_MAX → IDLE (abort).
- WAIT_T1: counts T1_CYC cycles, then goes to REPLY. din is ignored in WAIT_T1 and REPLY.
- REPLY: transmits 21 bits, MSB first: preamble 4'b1010, then REPLY_DATA[15:0], then a dummy 1.
- FM0 rules:
  - dout toggles at the start of every bit, including the first; the first bit therefore begins with dout=1;
  - a data-0 also toggles at BIT_CYC/2 into the bit;
  - a data-1 holds its level for the whole bit.
- After the last bit, dout is forced to 0 at the next cycle and the FSM returns to IDLE.
- Reset mid-reply: dout drops to 0 immediately (asynchronous).
- Frame arriving during WAIT_T1/REPLY: ignored entirely. No queueing.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE, DELIM, DATA, WAIT_T1, REPLY;
  - default timing constants;
  - preamble constant 4'b1010;
  - reply length 21.
- One natural sub-module: fm0_encoder. Inputs: start, a 21-bit word, BIT_CYC. Outputs: dout and done.
- The PIE decoder and FSM stay in optim_top.

Test Plan:
- Reset: hold rst_p=0 for 50 us, with din held high throughout → dout=0, FSM IDLE. Release and keep din high for 100 us → dout stays 0.
- Valid command: delimiter 625 cycles low, then 8 symbols for 8'hC3 (data-0 = 625 cycles, data-1 = 1250 cycles, each ending in a 250-cycle low), then din high → first dout rise 500 cycles after end-of-frame detection. The 21-bit FM0 waveform decodes to 1010_1010010101011010_1. dout=0 afterwards.
- Wrong code: same framing carrying 8'hC2 → dout stays 0 for the whole frame and 2 ms after.
- Bad delimiter: delimiter 400 cycles, and separately 800 cycles, followed by a valid 8'hC3 body → no reply.
- Wrong length: 9 bits whose first 8 are 8'hC3 → no reply. Stuck-low din for 3000 cycles in DATA → return to IDLE; a following valid frame is answered normally.
- Asynchronous reset mid-reply: assert rst_p=0 at reply bit 10 → dout=0 within the same cycle. Deassert and send a valid frame → full reply.
